// File: rtl/seq_pkg.sv
// Shared constants, config type and length check for the programmable sequence detector.
package seq_pkg;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);
  localparam int unsigned CNT_W   = 8;

  // Reset configuration reproduces the legacy overlapping 10101 detector.
  localparam logic [MAX_LEN-1:0] DEF_PAT = 8'b0001_0101;
  localparam int unsigned        DEF_LEN = 5;
  localparam bit                 DEF_OVL = 1'b1;

  typedef struct packed {
    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   len;
    logic               ovl;
  } cfg_t;

  function automatic logic len_ok(input int unsigned len, input int unsigned max_len);
    return (len >= 1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_match_cnt.sv
// Saturating match counter with synchronous reset and clear; sat is registered with the count.
module seq_match_cnt #(
  parameter int unsigned CNT_W = seq_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cnt_clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_n;

  // Clear has priority over a same-cycle increment.
  always_comb begin
    cnt_n = cnt;
    if (cnt_clr) begin
      cnt_n = '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt_n = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else begin
      cnt <= cnt_n;
      sat <= (cnt_n == CNT_MAX);
    end
  end

endmodule

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial bit-sequence detector with overlap control,
// one-cycle match pulse and saturating match counter.
module seq_detect_prog #(
  parameter int unsigned         MAX_LEN = seq_pkg::MAX_LEN,
  parameter int unsigned         LEN_W   = $clog2(MAX_LEN + 1),
  parameter int unsigned         CNT_W   = seq_pkg::CNT_W,
  parameter logic [MAX_LEN-1:0]  DEF_PAT = seq_pkg::DEF_PAT,
  parameter int unsigned         DEF_LEN = seq_pkg::DEF_LEN,
  parameter bit                  DEF_OVL = seq_pkg::DEF_OVL
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               x,
  input  logic               x_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LEN_W-1:0]   len_in,
  input  logic               ovl_in,
  input  logic               cnt_clr,
  output logic               z,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat
);

  // Only the newest MAX_LEN-1 bits need storing; the incoming bit completes the window.
  logic [MAX_LEN-2:0] hist;
  logic [MAX_LEN-1:0] hist_n;
  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   fill_n;
  logic               ovl;

  logic cfg_ok_c;
  logic sample_c;
  logic hit_c;
  logic cnt_zero_c;

  always_comb begin
    cfg_ok_c = seq_pkg::len_ok(32'(len_in), MAX_LEN);
    sample_c = x_valid && !cfg_load;
    hist_n   = {hist, x};
    mask     = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < 32'(len));
    end
    fill_n     = (fill >= len) ? len : fill + LEN_W'(1);
    hit_c      = sample_c && (fill_n == len) && ((hist_n & mask) == (pat & mask));
    cnt_zero_c = cnt_clr || (cfg_load && cfg_ok_c);
  end

  // A config load takes the cycle; any x sample alongside it is dropped.
  always_ff @(posedge clk) begin
    if (clr) begin
      pat     <= DEF_PAT;
      len     <= LEN_W'(DEF_LEN);
      ovl     <= DEF_OVL;
      hist    <= '0;
      fill    <= '0;
      z       <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      z       <= hit_c;
      cfg_err <= cfg_load && !cfg_ok_c;
      if (cfg_load) begin
        if (cfg_ok_c) begin
          pat  <= pat_in;
          len  <= len_in;
          ovl  <= ovl_in;
          hist <= '0;
          fill <= '0;
        end
      end else if (x_valid) begin
        hist <= hist_n[MAX_LEN-2:0];
        fill <= (hit_c && !ovl) ? '0 : fill_n;
      end
    end
  end

  seq_match_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .clr     (clr),
    .cnt_clr (cnt_zero_c),
    .inc     (hit_c),
    .cnt     (match_cnt),
    .sat     (cnt_sat)
  );

endmodule

// File: tb/tb_seq_detect_prog.sv
// Self-checking bench for seq_detect_prog: directed scenarios plus random traffic against a queue-based model.
module tb_seq_detect_prog;

  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_TOP = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       x = 1'b0;
  logic       x_valid = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] pat_in = '0;
  logic [3:0] len_in = '0;
  logic       ovl_in = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       z;
  logic       cfg_err;
  logic [3:0] match_cnt;
  logic       cnt_sat;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: bits seen since the last restart, newest at the back.
  bit         hq[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  int         m_cnt;
  bit         m_z;
  bit         m_err;

  seq_detect_prog #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .clr       (clr),
    .x         (x),
    .x_valid   (x_valid),
    .cfg_load  (cfg_load),
    .pat_in    (pat_in),
    .len_in    (len_in),
    .ovl_in    (ovl_in),
    .cnt_clr   (cnt_clr),
    .z         (z),
    .cfg_err   (cfg_err),
    .match_cnt (match_cnt),
    .cnt_sat   (cnt_sat)
  );

  always #5 clk = ~clk;

  task automatic model(input bit c, input bit xi, input bit xv, input bit ld,
                       input logic [7:0] p, input logic [3:0] l, input bit o, input bit cc);
    bit hit;
    m_z   = 0;
    m_err = 0;
    if (c) begin
      m_pat = 8'h15; m_len = 5; m_ovl = 1; m_cnt = 0;
      hq.delete();
      return;
    end
    if (ld) begin
      if (int'(l) >= 1 && int'(l) <= 8) begin
        m_pat = p; m_len = int'(l); m_ovl = o; m_cnt = 0;
        hq.delete();
      end else begin
        m_err = 1;
      end
    end else if (xv) begin
      hq.push_back(xi);
      if (hq.size() > m_len) void'(hq.pop_front());
      hit = (hq.size() == m_len);
      if (hit) begin
        for (int i = 0; i < m_len; i++) begin
          if (hq[m_len - 1 - i] != m_pat[i]) hit = 0;
        end
      end
      if (hit) begin
        m_z = 1;
        if (!m_ovl) hq.delete();
        m_cnt = (m_cnt < CNT_TOP) ? m_cnt + 1 : CNT_TOP;
      end
    end
    if (cc) m_cnt = 0;
  endtask

  task automatic step(input bit c, input bit xi, input bit xv, input bit ld,
                      input logic [7:0] p, input logic [3:0] l, input bit o, input bit cc);
    clr = c; x = xi; x_valid = xv; cfg_load = ld;
    pat_in = p; len_in = l; ovl_in = o; cnt_clr = cc;
    @(posedge clk);
    #1;
    model(c, xi, xv, ld, p, l, o, cc);
    clr = 0; x_valid = 0; cfg_load = 0; cnt_clr = 0;
  endtask

  task automatic feed(input bit b);
    step(0, b, 1, 0, 8'h00, 4'd0, 0, 0);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 8'h00, 4'd0, 0, 0);
    n_chk++;
    if ({z, cfg_err, match_cnt, cnt_sat} !== 7'b0) $display("FAIL reset_outputs got %b want 0", {z, cfg_err, match_cnt, cnt_sat});
    else n_pass++;
  endtask

  task automatic test_default_overlap();
    logic [6:0] bits = 7'b1010101;
    logic [6:0] zexp = 7'b0000101;
    for (int i = 6; i >= 0; i--) begin
      feed(bits[i]);
      n_chk++;
      if (z !== zexp[i] || z !== m_z) $display("FAIL ovl_z bit%0d got %b want %b", 7 - i, z, zexp[i]);
      else n_pass++;
    end
    n_chk++;
    if (match_cnt !== 4'd2) $display("FAIL ovl_cnt got %0d want 2", match_cnt);
    else n_pass++;
  endtask

  task automatic test_nonoverlap();
    logic [9:0] s1 = 10'b1010110101;
    logic [6:0] s2 = 7'b1010101;
    int zc = 0;
    step(0, 0, 0, 1, 8'b10101, 4'd5, 0, 0);
    n_chk++;
    if (match_cnt !== 4'd0 || cfg_err !== 1'b0) $display("FAIL nov_load cnt=%0d err=%b want 0 0", match_cnt, cfg_err);
    else n_pass++;
    for (int i = 9; i >= 0; i--) begin
      feed(s1[i]);
      n_chk++;
      if (z !== m_z) $display("FAIL nov_z1 bit%0d got %b want %b", 10 - i, z, m_z);
      else n_pass++;
    end
    n_chk++;
    if (match_cnt !== 4'd2) $display("FAIL nov_cnt got %0d want 2", match_cnt);
    else n_pass++;
    for (int i = 6; i >= 0; i--) begin
      feed(s2[i]);
      if (z) zc++;
    end
    n_chk++;
    if (zc != 1) $display("FAIL nov_single got %0d pulses want 1", zc);
    else n_pass++;
  endtask

  task automatic test_gaps();
    logic [6:0] s = 7'b1101110;
    step(0, 0, 0, 1, 8'b110, 4'd3, 1, 0);
    for (int i = 6; i >= 0; i--) begin
      if (i == 3) begin
        for (int g = 0; g < 2; g++) begin
          step(0, 1'($urandom), 0, 0, 8'h00, 4'd0, 0, 0);
          n_chk++;
          if (z !== 1'b0) $display("FAIL gap_z got %b want 0", z);
          else n_pass++;
        end
      end
      feed(s[i]);
      n_chk++;
      if (z !== m_z) $display("FAIL gap_stream bit%0d got %b want %b", 7 - i, z, m_z);
      else n_pass++;
    end
    n_chk++;
    if (match_cnt !== 4'd2 || z !== 1'b1) $display("FAIL gap_end cnt=%0d z=%b want 2 1", match_cnt, z);
    else n_pass++;
  endtask

  task automatic test_bad_cfg();
    logic [4:0] s = 5'b10101;
    logic [3:0] tail = 4'b0101;
    int zc = 0;
    step(1, 0, 0, 0, 8'h00, 4'd0, 0, 0);
    step(0, 0, 0, 1, 8'hff, 4'd0, 0, 0);
    n_chk++;
    if (cfg_err !== 1'b1) $display("FAIL bad_len0 err got %b want 1", cfg_err);
    else n_pass++;
    step(0, 1, 1, 1, 8'hff, 4'd9, 0, 0);
    n_chk++;
    if (cfg_err !== 1'b1 || z !== 1'b0) $display("FAIL bad_len9 err=%b z=%b want 1 0", cfg_err, z);
    else n_pass++;
    for (int i = 4; i >= 0; i--) feed(s[i]);
    n_chk++;
    if (z !== 1'b1 || cfg_err !== 1'b0) $display("FAIL bad_then_match z=%b err=%b want 1 0", z, cfg_err);
    else n_pass++;
    step(0, 1, 1, 1, 8'b10101, 4'd5, 1, 0);
    n_chk++;
    if (z !== 1'b0 || match_cnt !== 4'd0) $display("FAIL load_drop z=%b cnt=%0d want 0 0", z, match_cnt);
    else n_pass++;
    for (int i = 3; i >= 0; i--) begin
      feed(tail[i]);
      if (z) zc++;
    end
    n_chk++;
    if (zc != 0) $display("FAIL load_drop_fill got %0d pulses want 0", zc);
    else n_pass++;
    feed(0);
    feed(1);
    n_chk++;
    if (z !== 1'b1) $display("FAIL load_refill z got %b want 1", z);
    else n_pass++;
  endtask

  task automatic test_saturate();
    step(0, 0, 0, 1, 8'h01, 4'd1, 1, 0);
    for (int i = 0; i < 17; i++) begin
      feed(1);
      n_chk++;
      if (z !== 1'b1 || match_cnt !== 4'(m_cnt)) $display("FAIL sat_step%0d z=%b cnt=%0d want 1 %0d", i, z, match_cnt, m_cnt);
      else n_pass++;
    end
    n_chk++;
    if (match_cnt !== 4'd15 || cnt_sat !== 1'b1) $display("FAIL sat_end cnt=%0d sat=%b want 15 1", match_cnt, cnt_sat);
    else n_pass++;
    step(0, 1, 1, 0, 8'h00, 4'd0, 0, 1);
    n_chk++;
    if (z !== 1'b1 || match_cnt !== 4'd0 || cnt_sat !== 1'b0) $display("FAIL clr_hit z=%b cnt=%0d sat=%b want 1 0 0", z, match_cnt, cnt_sat);
    else n_pass++;
  endtask

  task automatic test_reset_midstream();
    logic [3:0] pre = 4'b1010;
    logic [3:0] post = 4'b0101;
    step(1, 0, 0, 0, 8'h00, 4'd0, 0, 0);
    for (int i = 3; i >= 0; i--) feed(pre[i]);
    step(1, 1, 1, 0, 8'h00, 4'd0, 0, 0);
    n_chk++;
    if ({z, cfg_err, match_cnt, cnt_sat} !== 7'b0) $display("FAIL mid_clr outs got %b want 0", {z, cfg_err, match_cnt, cnt_sat});
    else n_pass++;
    feed(1);
    n_chk++;
    if (z !== 1'b0) $display("FAIL mid_no_stale z got %b want 0", z);
    else n_pass++;
    for (int i = 3; i >= 0; i--) begin
      feed(post[i]);
      n_chk++;
      if (z !== (i == 0)) $display("FAIL mid_stream bit%0d z got %b want %b", 4 - i, z, (i == 0));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    bit c, xi, xv, ld, o, cc;
    logic [7:0] p;
    logic [3:0] l;
    step(1, 0, 0, 0, 8'h00, 4'd0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      c  = ($urandom_range(0, 99) == 0);
      ld = ($urandom_range(0, 24) == 0);
      xv = ($urandom_range(0, 3) != 0);
      xi = 1'($urandom);
      cc = ($urandom_range(0, 39) == 0);
      o  = 1'($urandom);
      p  = 8'($urandom);
      l  = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(1, 4));
      step(c, xi, xv, ld, p, l, o, cc);
      n_chk++;
      if (z !== m_z || cfg_err !== m_err || match_cnt !== 4'(m_cnt) || cnt_sat !== (m_cnt == CNT_TOP))
        $display("FAIL rand_cyc%0d z=%b err=%b cnt=%0d sat=%b want %b %b %0d %b",
                 n, z, cfg_err, match_cnt, cnt_sat, m_z, m_err, m_cnt, (m_cnt == CNT_TOP));
      else n_pass++;
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_default_overlap();
    test_nonoverlap();
    test_gaps();
    test_bad_cfg();
    test_saturate();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
